// File: rtl/sayeh_pkg.sv
// Shared definitions for the sequential ALU stage: opcodes, FSM state encoding
// and the default datapath width.
package sayeh_pkg;

  localparam int W_DEFAULT = 16;

  localparam logic [3:0] OP_PASSB = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_NOT   = 4'd3;
  localparam logic [3:0] OP_SHL   = 4'd4;
  localparam logic [3:0] OP_SHR   = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_CMP   = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } alu_state_e;

endpackage

// File: rtl/seq_alu_flags_if.sv
// Controller <-> ALU stage bundle: start/op/operands in, busy/done/result and
// status-register strobes out.
interface seq_alu_flags_if #(parameter int W = sayeh_pkg::W_DEFAULT);
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         res_we;
  logic         c_out;
  logic         z_out;
  logic         sr_load;

  modport master (
    output start, op, a, b, c_in,
    input  busy, done, result, res_we, c_out, z_out, sr_load
  );

  modport slave (
    input  start, op, a, b, c_in,
    output busy, done, result, res_we, c_out, z_out, sr_load
  );
endinterface

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first,
// MUL_W iterations counted down; done marks the final iteration.
module seq_alu_mul #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W/2-1:0]   a,
  input  logic [W/2-1:0]   b,
  output logic             done,
  output logic [W-1:0]     product_nxt
);
  localparam int MUL_W = W / 2;
  localparam int CW    = $clog2(MUL_W + 1);

  logic [W-1:0]     mcand_q, mcand_d;
  logic [MUL_W-1:0] mplier_q, mplier_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    if (start) begin
      mcand_d  = {{(W-MUL_W){1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CW'(MUL_W);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = {mcand_q[W-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[MUL_W-1:1]};
      cnt_d    = cnt_q - CW'(1);
      done     = (cnt_q == CW'(1));
    end
  end

  // Exposed pre-register so the top can latch the product on the last iteration.
  assign product_nxt = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/seq_alu_flags.sv
// Multi-cycle ALU stage feeding the status register (Cin/Zin/SRload).
// Define SEQ_ALU_DIV_EN to build the iterative unsigned divider (opcode 10).
//
// state   | meaning
// IDLE    | waiting for start; single-cycle ops resolve here
// MUL_RUN | shift-add multiply in progress (MUL_W cycles)
// DIV_RUN | restoring divide in progress (W cycles)
// DONE    | one-cycle completion: done, strobes and flags valid
module seq_alu_flags
  import sayeh_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  seq_alu_flags_if.slave bus
);
  localparam int MUL_W = W / 2;

  alu_state_e   state_q, state_d;
  logic [W-1:0] result_q, result_d;
  logic         c_out_q, c_out_d;
  logic         z_out_q, z_out_d;
  logic         res_we_q, res_we_d;
  logic         sr_load_q, sr_load_d;

  logic [W-1:0] sc_res;
  logic         sc_c, sc_z, sc_we, sc_ld;
  logic [W:0]   sum;

  logic         mul_start, mul_done;
  logic [W-1:0] mul_prod;

  assign mul_start = (state_q == S_IDLE) && bus.start && (bus.op == OP_MUL);

  seq_alu_mul #(.W(W)) u_mul (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (mul_start),
    .a           (bus.a[MUL_W-1:0]),
    .b           (bus.b[MUL_W-1:0]),
    .done        (mul_done),
    .product_nxt (mul_prod)
  );

`ifdef SEQ_ALU_DIV_EN
  localparam int DCW = $clog2(W + 1);

  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic           dz_q, dz_d;
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic [W:0]     rem_sh;
  logic           div_start;

  assign div_start = (state_q == S_IDLE) && bus.start && (bus.op == OP_DIV);

  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    dz_d      = dz_q;
    div_cnt_d = div_cnt_q;
    rem_sh    = {rem_q, quo_q[W-1]};
    if (div_start) begin
      quo_d     = bus.a;
      rem_d     = '0;
      dvs_d     = bus.b;
      dz_d      = (bus.b == '0);
      div_cnt_d = DCW'(W);
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - DCW'(1);
      // Zero divisor always "fits", which yields the all-ones quotient.
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d = rem_sh[W-1:0] - dvs_q;
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      dz_q      <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      dz_q      <= dz_d;
      div_cnt_q <= div_cnt_d;
    end
  end
`endif

  always_comb begin
    sc_res = result_q;
    sc_c   = c_out_q;
    sc_z   = z_out_q;
    sc_we  = 1'b1;
    sc_ld  = 1'b1;
    sum    = '0;
    case (bus.op)
      OP_PASSB: begin sc_res = bus.b;          sc_c = bus.c_in; end
      OP_AND:   begin sc_res = bus.a & bus.b;  sc_c = bus.c_in; end
      OP_OR:    begin sc_res = bus.a | bus.b;  sc_c = bus.c_in; end
      OP_NOT:   begin sc_res = ~bus.b;         sc_c = bus.c_in; end
      OP_SHL:   begin sc_res = {bus.b[W-2:0], 1'b0}; sc_c = bus.b[W-1]; end
      OP_SHR:   begin sc_res = {1'b0, bus.b[W-1:1]}; sc_c = bus.b[0];   end
      OP_ADD: begin
        sum    = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.c_in};
        sc_res = sum[W-1:0];
        sc_c   = sum[W];
      end
      OP_SUB: begin
        sum    = {1'b0, bus.a} - {1'b0, bus.b} - {{W{1'b0}}, bus.c_in};
        sc_res = sum[W-1:0];
        sc_c   = sum[W];
      end
      OP_CMP: begin
        sc_c  = (bus.a < bus.b);
        sc_z  = (bus.a == bus.b);
        sc_we = 1'b0;
      end
      default: begin
        sc_we = 1'b0;
        sc_ld = 1'b0;
      end
    endcase
    if (sc_ld && (bus.op != OP_CMP)) sc_z = (sc_res == '0);
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    c_out_d   = c_out_q;
    z_out_d   = z_out_q;
    res_we_d  = 1'b0;
    sr_load_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            state_d = S_MUL_RUN;
`ifdef SEQ_ALU_DIV_EN
          end else if (bus.op == OP_DIV) begin
            state_d = S_DIV_RUN;
`endif
          end else begin
            state_d   = S_DONE;
            result_d  = sc_res;
            c_out_d   = sc_c;
            z_out_d   = sc_z;
            res_we_d  = sc_we;
            sr_load_d = sc_ld;
          end
        end
      end
      S_MUL_RUN: begin
        if (mul_done) begin
          state_d   = S_DONE;
          result_d  = mul_prod;
          c_out_d   = 1'b0;
          z_out_d   = (mul_prod == '0);
          res_we_d  = 1'b1;
          sr_load_d = 1'b1;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      S_DIV_RUN: begin
        if (div_cnt_q == DCW'(1)) begin
          state_d   = S_DONE;
          result_d  = quo_d;
          c_out_d   = dz_q;
          z_out_d   = !dz_q && (quo_d == '0);
          res_we_d  = 1'b1;
          sr_load_d = 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      c_out_q   <= 1'b0;
      z_out_q   <= 1'b0;
      res_we_q  <= 1'b0;
      sr_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      c_out_q   <= c_out_d;
      z_out_q   <= z_out_d;
      res_we_q  <= res_we_d;
      sr_load_q <= sr_load_d;
    end
  end

  assign bus.busy    = (state_q == S_MUL_RUN) || (state_q == S_DIV_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.result  = result_q;
  assign bus.c_out   = c_out_q;
  assign bus.z_out   = z_out_q;
  assign bus.res_we  = res_we_q;
  assign bus.sr_load = sr_load_q;
endmodule

// File: tb/tb_seq_alu_flags.sv
// Self-checking bench for seq_alu_flags (W=16): directed table, multi-cycle
// corner sequences and randomized ops against an arithmetic reference model.
module tb_seq_alu_flags;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_flags_if #(.W(W)) bus ();
  seq_alu_flags #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] m_res;
  logic        m_c, m_z;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] res;
    logic        c, z, we, ld;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] op, logic [15:0] a, logic [15:0] b, logic cin,
                              logic [15:0] res, logic c, logic z, logic we, logic ld, int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cin = cin;
    v.res = res; v.c = c; v.z = z; v.we = we; v.ld = ld; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Caller is #1 after a posedge with the DUT idle; returns the same way.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output logic [15:0] r, output logic c, output logic z,
                        output logic we, output logic ld, output int lat);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.c_in = cin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = bus.result; c = bus.c_out; z = bus.z_out; we = bus.res_we; ld = bus.sr_load;
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, output logic [15:0] r, output logic c, output logic z,
                       output logic we, output logic ld, output int lat);
    int ai, bi, s;
    ai = int'(a); bi = int'(b);
    r = m_res; c = m_c; z = m_z; we = 1'b1; ld = 1'b1; lat = 1;
    case (op)
      4'd0: begin r = b; c = cin; end
      4'd1: begin r = a & b; c = cin; end
      4'd2: begin r = a | b; c = cin; end
      4'd3: begin r = ~b; c = cin; end
      4'd4: begin r = 16'((bi * 2) % 65536); c = (bi >= 32768); end
      4'd5: begin r = 16'(bi / 2); c = (bi % 2 == 1); end
      4'd6: begin s = ai + bi + int'(cin); r = 16'(s % 65536); c = (s > 65535); end
      4'd7: begin s = ai - bi - int'(cin); c = (s < 0); r = 16'((s + 131072) % 65536); end
      4'd8: begin r = 16'((ai % 256) * (bi % 256)); c = 1'b0; lat = 9; end
      4'd9: begin c = (ai < bi); z = (ai == bi); we = 1'b0; end
`ifdef SEQ_ALU_DIV_EN
      4'd10: begin
        lat = 17;
        if (bi == 0) begin r = 16'hFFFF; c = 1'b1; end
        else begin r = 16'(ai / bi); c = 1'b0; end
      end
`endif
      default: begin we = 1'b0; ld = 1'b0; end
    endcase
    if (ld && op != 4'd9) z = (r == 16'd0);
    if (ld) begin m_res = r; m_c = c; m_z = z; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},    {31'd0, bus.busy},    32'd0);
    chk({tag, "_done"},    {31'd0, bus.done},    32'd0);
    chk({tag, "_result"},  {16'd0, bus.result},  32'd0);
    chk({tag, "_res_we"},  {31'd0, bus.res_we},  32'd0);
    chk({tag, "_c_out"},   {31'd0, bus.c_out},   32'd0);
    chk({tag, "_z_out"},   {31'd0, bus.z_out},   32'd0);
    chk({tag, "_sr_load"}, {31'd0, bus.sr_load}, 32'd0);
  endtask

  initial begin
    logic [15:0] r, er;
    logic c, z, we, ld, ec, ez, ewe, eld;
    int lat, elat, cyc, busy_cnt, done_cnt;
    logic [3:0] op;
    logic [15:0] a, b;
    logic cin;

    bus.start = 1'b0; bus.op = 4'd0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    run_op(4'd0, 16'h0, 16'hABCD, 1'b1, r, c, z, we, ld, lat);
    chk("pre_rst_result", {16'd0, r}, 32'h0000ABCD);
    bus.start = 1'b1; bus.op = 4'd8; bus.a = 16'h00FF; bus.b = 16'h00FF;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midmul_rst");
    @(negedge clk); rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    chk("midmul_no_done", done_cnt, 0);
    chk("midmul_result_kept0", {16'd0, bus.result}, 32'd0);

    // Directed table
    tbl.push_back(mk(4'd6, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 1, 1, 1, 1));
    tbl.push_back(mk(4'd7, 16'h0003, 16'h0005, 1'b1, 16'hFFFD, 1, 0, 1, 1, 1));
    tbl.push_back(mk(4'd9, 16'h1234, 16'h1234, 1'b0, 16'hFFFD, 0, 1, 0, 1, 1));
    tbl.push_back(mk(4'd9, 16'h0001, 16'h0002, 1'b0, 16'hFFFD, 1, 0, 0, 1, 1));
    tbl.push_back(mk(4'd4, 16'h0000, 16'h8001, 1'b0, 16'h0002, 1, 0, 1, 1, 1));
    tbl.push_back(mk(4'd1, 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1, 1, 1, 1, 1));
`ifndef SEQ_ALU_DIV_EN
    tbl.push_back(mk(4'd10, 16'h0064, 16'h0007, 1'b0, 16'h0000, 1, 1, 0, 0, 1));
`endif
    tbl.push_back(mk(4'd15, 16'h1111, 16'h2222, 1'b0, 16'h0000, 1, 1, 0, 0, 1));
    tbl.push_back(mk(4'd8, 16'h00FF, 16'h00FF, 1'b1, 16'hFE01, 0, 0, 1, 1, 9));
    tbl.push_back(mk(4'd5, 16'h0000, 16'h0001, 1'b0, 16'h0000, 1, 1, 1, 1, 1));
    tbl.push_back(mk(4'd3, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1, 1, 1, 1, 1));
    tbl.push_back(mk(4'd2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 0, 1, 1, 1, 1));
    tbl.push_back(mk(4'd0, 16'h0000, 16'h8000, 1'b1, 16'h8000, 1, 0, 1, 1, 1));
    tbl.push_back(mk(4'd8, 16'h1234, 16'h5600, 1'b0, 16'h0000, 0, 1, 1, 1, 9));
`ifdef SEQ_ALU_DIV_EN
    tbl.push_back(mk(4'd10, 16'h0064, 16'h0007, 1'b0, 16'h000E, 0, 0, 1, 1, 17));
    tbl.push_back(mk(4'd10, 16'h0005, 16'h0000, 1'b0, 16'hFFFF, 1, 0, 1, 1, 17));
`endif
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, r, c, z, we, ld, lat);
      chk($sformatf("tbl%0d_result", i), {16'd0, r}, {16'd0, tbl[i].res});
      chk($sformatf("tbl%0d_c_out", i), {31'd0, c}, {31'd0, tbl[i].c});
      chk($sformatf("tbl%0d_z_out", i), {31'd0, z}, {31'd0, tbl[i].z});
      chk($sformatf("tbl%0d_res_we", i), {31'd0, we}, {31'd0, tbl[i].we});
      chk($sformatf("tbl%0d_sr_load", i), {31'd0, ld}, {31'd0, tbl[i].ld});
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
    end

    // Multiply with a stray start while busy
    bus.start = 1'b1; bus.op = 4'd8; bus.a = 16'h00FF; bus.b = 16'h00FF; bus.c_in = 1'b0;
    @(posedge clk); #1 bus.start = 1'b0;
    cyc = 1; busy_cnt = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) busy_cnt++;
      if (cyc == 3) begin
        bus.start = 1'b1; bus.op = 4'd6; bus.a = 16'h0001; bus.b = 16'h0001;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk("mulign_latency", cyc, 9);
    chk("mulign_busy_cycles", busy_cnt, 8);
    chk("mulign_busy_at_done", {31'd0, bus.busy}, 32'd0);
    chk("mulign_result", {16'd0, bus.result}, 32'h0000FE01);
    chk("mulign_c_out", {31'd0, bus.c_out}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    chk("mulign_no_extra_done", done_cnt, 0);

    // Randomized ops against the reference model, starting from a fresh reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    m_res = 16'd0; m_c = 1'b0; m_z = 1'b0;
    for (int i = 0; i < 300; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = 16'd0;
      cin = 1'($urandom);
      model(op, a, b, cin, er, ec, ez, ewe, eld, elat);
      run_op(op, a, b, cin, r, c, z, we, ld, lat);
      chk($sformatf("rnd%0d_op%0d_result", i, op), {16'd0, r}, {16'd0, er});
      chk($sformatf("rnd%0d_op%0d_c_out", i, op), {31'd0, c}, {31'd0, ec});
      chk($sformatf("rnd%0d_op%0d_z_out", i, op), {31'd0, z}, {31'd0, ez});
      chk($sformatf("rnd%0d_op%0d_res_we", i, op), {31'd0, we}, {31'd0, ewe});
      chk($sformatf("rnd%0d_op%0d_sr_load", i, op), {31'd0, ld}, {31'd0, eld});
      chk($sformatf("rnd%0d_op%0d_latency", i, op), lat, elat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
